// File: rtl/trigger_gen_if.sv
// Control/status bundle for the trigger generator: request inputs plus registered status.
interface trigger_gen_if #(
    parameter int CNT_LEN = 8,
    parameter int GAP_LEN = 16
);
    logic               start;
    logic               cont;
    logic [CNT_LEN-1:0] pulse_len;
    logic [GAP_LEN-1:0] gap_len;
    logic               trig;
    logic               busy;
    logic               done;
    logic [7:0]         pulse_cnt;

    modport master (
        output start, cont, pulse_len, gap_len,
        input  trig, busy, done, pulse_cnt
    );

    modport slave (
        input  start, cont, pulse_len, gap_len,
        output trig, busy, done, pulse_cnt
    );
endinterface

// File: rtl/trigger_gen.sv
// Transducer trigger sequencer: high pulse of pulse_len cycles, then a gap of
// max(gap_len,1) cycles, optionally repeating back-to-back in continuous mode.
module trigger_gen #(
    parameter int CNT_LEN = 8,
    parameter int GAP_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    trigger_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_LEN-1:0] pcnt_q;
    logic [GAP_LEN-1:0] glen_q, gcnt_q;
    logic [7:0]         pulse_cnt_q;
    logic               trig_q, busy_q, done_q;
    logic               trig_d, busy_d, done_d, launch;
    logic               pulse_end, gap_end;

    // Down-counters hold "cycles remaining after this one", so zero marks the last cycle.
    assign pulse_end = (pcnt_q == '0);
    assign gap_end   = (gcnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start && (bus.pulse_len != '0)) state_d = PULSE;
            PULSE: if (pulse_end) state_d = GAP;
            GAP:   if (gap_end)
                       state_d = (bus.cont && (bus.pulse_len != '0)) ? PULSE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so trig rises on the launching edge.
    always_comb begin
        launch = (state_d == PULSE) && (state_q != PULSE);
        trig_d = (state_d == PULSE);
        busy_d = (state_d != IDLE);
        done_d = ((state_q == IDLE) && bus.start && (bus.pulse_len == '0)) ||
                 ((state_q == GAP) && gap_end);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q      <= '0;
            glen_q      <= '0;
            gcnt_q      <= '0;
            pulse_cnt_q <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            trig_q <= trig_d;
            busy_q <= busy_d;
            done_q <= done_d;
            if (launch) begin
                pcnt_q      <= bus.pulse_len - 1'b1;
                glen_q      <= bus.gap_len;
                pulse_cnt_q <= pulse_cnt_q + 8'd1;
            end else if (state_q == PULSE) begin
                if (pulse_end) gcnt_q <= (glen_q == '0) ? '0 : glen_q - 1'b1;
                else           pcnt_q <= pcnt_q - 1'b1;
            end else if ((state_q == GAP) && !gap_end) begin
                gcnt_q <= gcnt_q - 1'b1;
            end
        end
    end

    assign bus.trig      = trig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;
endmodule

// File: tb/tb_trigger_gen.sv
// Scoreboard bench for trigger_gen: per-cycle expected {trig,busy,done,pulse_cnt} queued from the scenario.
module tb_trigger_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trigger_gen_if #(.CNT_LEN(8), .GAP_LEN(16)) bus ();
    trigger_gen #(.CNT_LEN(8), .GAP_LEN(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    string       cur_tag  = "init";
    logic [7:0]  exp_cnt  = 8'd0;
    logic [10:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit t, input bit b, input bit d, input logic [7:0] c);
        sb.push_back({t, b, d, c});
    endtask

    // One sequence as the spec describes it; d0 marks a done strobe landing on the first pulse cycle.
    task automatic push_seq(input int pl, input int gl, input bit d0);
        exp_cnt = exp_cnt + 8'd1;
        for (int i = 0; i < pl; i++) push(1'b1, 1'b1, (i == 0) && d0, exp_cnt);
        for (int i = 0; i < ((gl == 0) ? 1 : gl); i++) push(1'b0, 1'b1, 1'b0, exp_cnt);
    endtask

    task automatic step();
        logic [10:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            chk({cur_tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(cur_tag, {21'd0, bus.trig, bus.busy, bus.done, bus.pulse_cnt}, {21'd0, e});
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.start = 1'b0; bus.cont = 1'b0; bus.pulse_len = '0; bus.gap_len = '0;
        #17;
        chk("reset_outputs", {21'd0, bus.trig, bus.busy, bus.done, bus.pulse_cnt}, 32'd0);

        // Single shot, starting on the very first edge after reset release; inputs change mid-sequence.
        @(posedge clk); #1;
        rst = 1'b1;
        cur_tag = "single"; bus.pulse_len = 8'd10; bus.gap_len = 16'd20; bus.start = 1'b1;
        push_seq(10, 20, 1'b0); push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt);
        step(); bus.start = 1'b0; bus.pulse_len = 8'd3; bus.gap_len = 16'd2;
        drain();

        cur_tag = "zero_len"; bus.pulse_len = 8'd0; bus.gap_len = 16'd5; bus.start = 1'b1;
        push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt); push(0, 0, 0, exp_cnt);
        step(); bus.start = 1'b0;
        drain();

        cur_tag = "cont"; bus.pulse_len = 8'd3; bus.gap_len = 16'd5; bus.cont = 1'b1; bus.start = 1'b1;
        push_seq(3, 5, 1'b0); push_seq(3, 5, 1'b1); push_seq(3, 5, 1'b1);
        push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt);
        step(); bus.start = 1'b0;
        steps(19); bus.cont = 1'b0;
        drain();

        cur_tag = "gap0_busy_start"; bus.pulse_len = 8'd2; bus.gap_len = 16'd0; bus.start = 1'b1;
        push_seq(2, 0, 1'b0); push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt); push(0, 0, 0, exp_cnt);
        steps(4); bus.start = 1'b0;
        drain();

        cur_tag = "rst_mid_pulse"; bus.pulse_len = 8'd50; bus.gap_len = 16'd4; bus.start = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        for (int i = 0; i < 20; i++) push(1, 1, 0, exp_cnt);
        step(); bus.start = 1'b0;
        drain();
        #2 rst = 1'b0;
        #1 chk("rst_async", {21'd0, bus.trig, bus.busy, bus.done, bus.pulse_cnt}, 32'd0);
        exp_cnt = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cur_tag = "post_rst_idle";
        push(0, 0, 0, exp_cnt); push(0, 0, 0, exp_cnt);
        drain();
        cur_tag = "post_rst_full"; bus.start = 1'b1;
        push_seq(50, 4, 1'b0); push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt);
        step(); bus.start = 1'b0;
        drain();

        cur_tag = "wrap"; bus.pulse_len = 8'd1; bus.gap_len = 16'd1; bus.cont = 1'b1; bus.start = 1'b1;
        push_seq(1, 1, 1'b0);
        for (int k = 1; k < 256; k++) push_seq(1, 1, 1'b1);
        push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt);
        step(); bus.start = 1'b0;
        steps(510); bus.cont = 1'b0;
        drain();
        chk("wrap_count", {24'd0, bus.pulse_cnt}, 32'd1);

        cur_tag = "max_len"; bus.pulse_len = 8'd255; bus.gap_len = 16'd3; bus.start = 1'b1;
        push_seq(255, 3, 1'b0); push(0, 0, 1, exp_cnt); push(0, 0, 0, exp_cnt);
        step(); bus.start = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/trigger_gen.md
TRIGGER_GEN -- requirements
Module: trigger_gen

Interface
REQ-001 The module SHALL have parameter CNT_LEN, default 8, giving the width of the pulse-length input and counter.
REQ-002 The module SHALL have parameter GAP_LEN, default 16, giving the width of the gap-length input and counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request one trigger sequence; sampled on clk rising edge.
REQ-006 Port cont  input  1  continuous mode; when 1 at the end of a gap, the sequence repeats.
REQ-007 Port pulse_len  input  CNT_LEN  trigger high time in clk cycles.
REQ-008 Port gap_len  input  GAP_LEN  low/listen time after the pulse, in clk cycles.
REQ-009 Port trig  output  1  trigger pulse to transducer; registered.
REQ-010 Port busy  output  1  sequence in progress; registered.
REQ-011 Port done  output  1  one-cycle strobe at end of each sequence; registered.
REQ-012 Port pulse_cnt  output  8  count of pulses emitted since reset; registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, PULSE, GAP.
REQ-014 In IDLE with start=1 and pulse_len!=0, it SHALL latch pulse_len and gap_len and enter PULSE on the same edge.
REQ-015 In IDLE with start=1 and pulse_len=0, it SHALL stay in IDLE, keep trig=0, and assert done for one cycle.
REQ-016 trig SHALL be 1 exactly while the state is PULSE; latency start-sampled-edge to trig=1 is 0 edges (trig rises on the sampling edge).
REQ-017 PULSE SHALL last exactly the latched pulse_len cycles, then enter GAP.
REQ-018 GAP SHALL last max(latched gap_len,1) cycles.
REQ-019 At the edge ending GAP, done SHALL be 1 for the following single cycle.
REQ-020 At GAP end with cont=1, the module SHALL re-latch pulse_len/gap_len and re-enter PULSE on the same edge (no IDLE cycle); if the new pulse_len=0, it SHALL go to IDLE instead.
REQ-021 At GAP end with cont=0, the module SHALL enter IDLE.
REQ-022 busy SHALL be 1 whenever the state is PULSE or GAP, 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1; latched lengths SHALL NOT change mid-sequence when pulse_len/gap_len inputs change.
REQ-024 pulse_cnt SHALL increment by 1 on every PULSE entry and wrap 255->0.
REQ-025 Internal counters SHALL be CNT_LEN/GAP_LEN bits; pulse_len=2^CNT_LEN-1 SHALL give exactly that many high cycles without overflow.

Reset
REQ-026 On rst=0 all outputs SHALL clear immediately, asynchronously of clk: trig=0, busy=0, done=0, pulse_cnt=0, state IDLE, latched lengths 0.
REQ-027 Reset asserted mid-PULSE SHALL drop trig without waiting for a clock edge; after release the module SHALL wait in IDLE for a new start.
REQ-028 The first edge after rst returns to 1 SHALL be able to accept start.

Verification
REQ-029 Single shot: pulse_len=10, gap_len=20, cont=0, start 1 cycle -> trig high 10 cycles, low 20, done 1 cycle, busy high 30 cycles, pulse_cnt=1.
REQ-030 Zero length: pulse_len=0, start -> trig never rises, done 1 cycle next cycle, busy stays 0, pulse_cnt=0.
REQ-031 Continuous: pulse_len=3, gap_len=5, cont=1 for 3 sequences then 0 -> period 8 cycles, 3 done strobes, busy continuously high 24 cycles, pulse_cnt=3.
REQ-032 Gap zero/start while busy: gap_len=0, pulse_len=2, extra start pulses during PULSE -> GAP lasts 1 cycle, only one sequence runs.
REQ-033 Reset mid-pulse: pulse_len=50, assert rst=0 at cycle 20 between edges -> trig falls immediately, pulse_cnt=0; new start after release gives full 50-cycle pulse.
REQ-034 Wrap: 256 sequences with pulse_len=1, gap_len=1 -> pulse_cnt returns to 0; pulse_len=255 -> exactly 255 high cycles.
